// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute unit: operation codes as produced
// by the ALU decoder, execute-unit FSM states and shift-amount sizing.
package alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int SHAMT_W  = $clog2(XLEN_DEF);

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b00001,
        OP_SLL  = 5'b00010,
        OP_SLT  = 5'b00011,
        OP_SLTU = 5'b00100,
        OP_XOR  = 5'b00101,
        OP_SRL  = 5'b00110,
        OP_SRA  = 5'b00111,
        OP_OR   = 5'b01000,
        OP_AND  = 5'b01001,
        OP_BEQ  = 5'b01010,
        OP_BNE  = 5'b01011,
        OP_BLT  = 5'b01100,
        OP_BGE  = 5'b01101,
        OP_BLTU = 5'b01110,
        OP_BGEU = 5'b01111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exu_state_e;

    // Shifts are the only operations that take the bit-serial path.
    function automatic logic is_shift_op(input logic [4:0] code);
        return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_comb_core.sv
// Single-cycle part of the execute unit: add/sub, logic, set-less-than and
// branch-condition evaluation. Shift codes and reserved codes yield zero here;
// shifts are handled serially by the enclosing unit.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] result,
    output logic            taken
);

    logic lt_signed;
    logic lt_unsigned;
    logic equal;

    assign lt_signed   = $signed(src_a) < $signed(src_b);
    assign lt_unsigned = src_a < src_b;
    assign equal       = src_a == src_b;

    // Decode the operation; branch codes produce a zero result and a condition.
    always_comb begin
        result = '0;
        taken  = 1'b0;
        case (alu_control)
            OP_ADD:  result = src_a + src_b;
            OP_SUB:  result = src_a - src_b;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
            OP_XOR:  result = src_a ^ src_b;
            OP_OR:   result = src_a | src_b;
            OP_AND:  result = src_a & src_b;
            OP_BEQ:  taken  = equal;
            OP_BNE:  taken  = !equal;
            OP_BLT:  taken  = lt_signed;
            OP_BGE:  taken  = !lt_signed;
            OP_BLTU: taken  = lt_unsigned;
            OP_BGEU: taken  = !lt_unsigned;
            default: begin
                result = '0;
                taken  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit with valid/ready on both sides. Single-cycle ops are
// registered straight into the result; shifts move one bit position per cycle
// through a shift register while the unit reports busy and refuses new work.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    exu_state_e      state_reg, state_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            branch_reg, branch_next;
    logic [XLEN-1:0] shift_reg, shift_next;
    logic [SHW-1:0]  count_reg, count_next;
    logic [4:0]      shop_reg, shop_next;

    logic [XLEN-1:0] core_result;
    logic            core_taken;
    logic [XLEN-1:0] shift_step;
    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            shift_left;
    logic            fill_bit;

    alu_comb_core #(
        .XLEN (XLEN)
    ) u_core (
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .result      (core_result),
        .taken       (core_taken)
    );

    assign shamt    = src_b[SHW-1:0];
    assign in_ready = !rst && !flush &&
                      ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    assign out_valid    = (state_reg == DONE);
    assign busy         = (state_reg == SHIFT);
    assign result       = result_reg;
    assign branch_taken = branch_reg;

    // One-position shift network: SLL pulls from the lower neighbour, SRL/SRA
    // from the upper one, with the vacated top bit taking the fill value.
    assign shift_left = (shop_reg == OP_SLL);
    assign fill_bit   = (shop_reg == OP_SRA) && shift_reg[XLEN-1];

    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign shift_step[gi] = shift_left ? 1'b0 : shift_reg[gi+1];
            end else if (gi == XLEN - 1) begin : g_msb
                assign shift_step[gi] = shift_left ? shift_reg[gi-1] : fill_bit;
            end else begin : g_mid
                assign shift_step[gi] = shift_left ? shift_reg[gi-1] : shift_reg[gi+1];
            end
        end
    endgenerate

    // Next-state logic: accept in IDLE or on a DONE hand-off, run the serial
    // shift, and let flush drop back to IDLE without touching the result.
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        branch_next = branch_reg;
        shift_next  = shift_reg;
        count_next  = count_reg;
        shop_next   = shop_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    if (is_shift_op(alu_control) && (shamt != '0)) begin
                        shift_next = src_a;
                        count_next = shamt;
                        shop_next  = alu_control;
                        state_next = SHIFT;
                    end else begin
                        // A zero-distance shift is just operand A.
                        result_next = is_shift_op(alu_control) ? src_a : core_result;
                        branch_next = core_taken;
                        state_next  = DONE;
                    end
                end else if ((state_reg == DONE) && out_ready) begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                shift_next = shift_step;
                count_next = count_reg - SHW'(1);
                if (count_reg == SHW'(1)) begin
                    result_next = shift_step;
                    branch_next = 1'b0;
                    state_next  = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next  = IDLE;
            result_next = result_reg;
            branch_next = branch_reg;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            branch_reg <= 1'b0;
            shift_reg  <= '0;
            count_reg  <= '0;
            shop_reg   <= OP_SLL;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            branch_reg <= branch_next;
            shift_reg  <= shift_next;
            count_reg  <= count_next;
            shop_reg   <= shop_next;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes the reference result
// at each accept, a monitor pops and compares on every output hand-off.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        branch_taken;
    logic        busy;

    typedef struct packed {
        logic [31:0] res;
        logic        taken;
        int          lat;
        int          acc;
        logic [4:0]  op;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          rdy_rand = 0;
    bit          first_seen = 0;
    logic [31:0] last_res = 32'h0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_control  (alu_control),
        .src_a        (src_a),
        .src_b        (src_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Reference model: RV32I semantics written directly from the op table.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int acc);
        exp_t e;
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        e.res = 32'h0;
        e.taken = 1'b0;
        e.acc = acc;
        e.op = op;
        e.lat = 1;
        case (op)
            5'd0:  e.res = a + b;
            5'd1:  e.res = a - b;
            5'd2:  e.res = a << sh;
            5'd3:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  e.res = (a < b) ? 32'd1 : 32'd0;
            5'd5:  e.res = a ^ b;
            5'd6:  e.res = a >> sh;
            5'd7:  e.res = $signed(a) >>> sh;
            5'd8:  e.res = a | b;
            5'd9:  e.res = a & b;
            5'd10: e.taken = (a == b);
            5'd11: e.taken = (a != b);
            5'd12: e.taken = ($signed(a) < $signed(b));
            5'd13: e.taken = ($signed(a) >= $signed(b));
            5'd14: e.taken = (a < b);
            5'd15: e.taken = (a >= b);
            default: begin
                e.res = 32'h0;
                e.taken = 1'b0;
            end
        endcase
        if ((op == 5'd2 || op == 5'd6 || op == 5'd7) && sh != 0) e.lat = int'(sh) + 1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Offer one op (called at posedge+1); returns just after the accept edge.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, output int waited);
        int acc_c;
        waited = 0;
        in_valid = 1'b1;
        alu_control = op;
        src_a = a;
        src_b = b;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: op %0d never accepted", op);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end else begin
            acc_c = cyc;
            @(posedge clk);
            if (push) sb.push_back(model(op, a, b, acc_c));
            #1;
            in_valid = 1'b0;
            alu_control = 5'($urandom);
            src_a = $urandom;
            src_b = $urandom;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: latency on first out_valid of an item, data on hand-off.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got result %h expected no output", result);
            end else begin
                if (!first_seen) begin
                    chk("latency", cyc - sb[0].acc, sb[0].lat);
                    first_seen = 1;
                end
                if (out_ready) begin
                    exp_t e;
                    e = sb.pop_front();
                    first_seen = 0;
                    last_res = e.res;
                    chk("result", result, e.res);
                    chk("branch_taken", {31'b0, branch_taken}, {31'b0, e.taken});
                    $display("txn op=%0d result=%h taken=%b expect %h/%b",
                             e.op, result, branch_taken, e.res, e.taken);
                end
            end
        end
    end

    initial begin
        int w;
        int ng;
        logic [4:0] op;
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        alu_control = 5'd0;
        src_a = 32'h0;
        src_b = 32'h0;
        out_ready = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_result", result, 32'h0);
        chk("rst_branch", {31'b0, branch_taken}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;

        // ADD, then back-to-back SUB/SLTU.
        send(5'd0, 32'd5, 32'd7, 1, w);
        send(5'd1, 32'd0, 32'd1, 1, w);
        chk("b2b_first_wait", w, 0);
        send(5'd4, 32'd0, 32'hFFFF_FFFF, 1, w);
        chk("b2b_second_wait", w, 0);

        // SRA by 4: busy and not ready for four cycles.
        send(5'd7, 32'h8000_0000, 32'd4, 1, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sra_busy", {31'b0, busy}, 1);
            chk("sra_in_ready", {31'b0, in_ready}, 0);
        end
        @(posedge clk);
        #1;
        send(5'd2, 32'h1234_5678, 32'd0, 1, w);

        // Branch conditions.
        send(5'd12, 32'hFFFF_FFFF, 32'd1, 1, w);
        send(5'd14, 32'hFFFF_FFFF, 32'd1, 1, w);
        send(5'd10, 32'hCAFE_0001, 32'hCAFE_0001, 1, w);
        drain();

        // Back-pressure: hold out_ready low for 3 cycles in DONE.
        out_ready = 1'b0;
        send(5'd0, 32'h100, 32'h23, 1, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'b0, out_valid}, 1);
            chk("stall_result", result, 32'h123);
            chk("stall_in_ready", {31'b0, in_ready}, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(5'd5, 32'hF0F0_0000, 32'h0FF0_0000, 1, w);
        chk("stall_release_wait", w, 0);
        drain();

        // Flush during cycle 2 of a 10-position SRL.
        send(5'd6, 32'hF000_0000, 32'd10, 0, w);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'b0, busy}, 0);
        chk("flush_in_ready_after", {31'b0, in_ready}, 1);
        chk("flush_keeps_result", result, last_res);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("flush_no_out_valid", {31'b0, out_valid}, 0);
        end
        @(posedge clk);
        #1;

        // Reset in the middle of a shift.
        send(5'd2, 32'h0000_0001, 32'd10, 0, w);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_branch", {31'b0, branch_taken}, 0);
        chk("midrst_in_ready_after", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure.
        rdy_rand = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(16, 31));
            else op = 5'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = a;
            if ($urandom_range(0, 3) == 0) b = b & 32'h3;
            send(op, a, b, 1, w);
            if ($urandom_range(0, 4) == 0) begin
                ng = $urandom_range(1, 3);
                repeat (ng) @(posedge clk);
                #1;
            end
        end
        rdy_rand = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle RV32I execute unit consuming the 5-bit `alu_control` code produced by the ALU decoder. Arithmetic, logic, compare and branch-condition operations complete in one cycle. Shifts run bit-serially, one position per cycle, to save area. It sits in the EX stage behind a valid/ready handshake on both sides, so the pipeline stalls on long shifts and on downstream back-pressure.

## Interface
- `XLEN`, default 32: datapath width; shift amount is `src_b[$clog2(XLEN)-1:0]`.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset; one clock; synchronous, active-high.
- `flush` input 1: synchronous abort of the in-flight operation.
- `in_valid` input 1: operation offered.
- `in_ready` output 1: unit accepts the operation this cycle.
- `alu_control` input 5: operation code, encoding below.
- `src_a` input XLEN: operand A.
- `src_b` input XLEN: operand B.
- `out_valid` output 1: result held valid.
- `out_ready` input 1: consumer takes the result.
- `result` output XLEN: registered result.
- `branch_taken` output 1: registered branch condition.
- `busy` output 1: serial shift in progress.

## Operation
- Encoding:
  - 00000 ADD; 00001 SUB; 00010 SLL; 00011 SLT; 00100 SLTU; 00101 XOR; 00110 SRL; 00111 SRA; 01000 OR; 01001 AND.
  - Branch codes: 01010 BEQ; 01011 BNE; 01100 BLT; 01101 BGE; 01110 BLTU; 01111 BGEU.
  - Codes 1xxxx are reserved: result 0, branch_taken 0.
- Arithmetic: add and subtract wrap modulo 2^XLEN. SLT/SLTU produce 0 or 1 zero-extended. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
- Branch codes: result = 0, branch_taken = condition. All non-branch codes: branch_taken = 0.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE: on accept of a non-shift op, or of a shift with shamt = 0 (result = src_a), register the result and go to DONE. On accept of a shift with shamt ≠ 0, load the shift register with src_a and the counter with shamt, then go to SHIFT.
  - SHIFT: each cycle shift by 1 and decrement the counter. SLL fills with 0, SRL with 0, SRA with the sign bit. When the counter equals 1, perform the last step and go to DONE.
  - DONE: out_valid = 1; result and branch_taken are held stable until out_ready. With out_ready and no new accept, go to IDLE. With out_ready and a simultaneous accept, process the new op exactly as from IDLE.
- `in_ready` = !rst && !flush && (state == IDLE || (state == DONE && out_ready)).
- `busy` = (state == SHIFT).
- flush (any state): go to IDLE next cycle, out_valid = 0; the cycle's input is not accepted. The result register keeps its old value.
- rst overrides flush and all handshakes.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, branch_taken 0, busy 0. in_ready is 0 while rst is high and 1 in the first cycle after.
- Latency is measured from the accept edge to the first out_valid cycle:
  - Non-shift ops and shamt = 0: 1 cycle.
  - Shifts: shamt + 1 cycles.
- Throughput: 1 op/cycle for non-shift ops while out_ready is held high.
- An out_ready low in DONE stalls indefinitely with no state change.
- rst asserted mid-shift aborts the shift; the reset values apply at the next edge.
- Operands are sampled only at the accept edge; src changes after that are ignored.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_op_e`: 5-bit enum with the encoding above, shared with the decoder.
  - `exu_state_e` {IDLE, SHIFT, DONE}.
  - A localparam for the shamt width.
- Sub-module `alu_comb_core`: purely combinational single-cycle ops and branch compare; outputs result and taken.
- The FSM, shift register and counter live in `alu_exec_unit`.

## Test plan
- ADD 5 + 7 with out_ready = 1 -> out_valid one cycle after accept, result 0x0000000C, branch_taken 0.
- SUB 0 − 1, then SLTU 0 < 0xFFFFFFFF issued back-to-back -> results 0xFFFFFFFF then 0x00000001 on consecutive cycles, in_ready constantly 1.
- SRA src_a = 0x80000000, src_b = 4 -> busy for 4 cycles, in_ready 0 throughout, result 0xF8000000 on cycle 5. SLL by 0 -> result = src_a after 1 cycle.
- BLT src_a = 0xFFFFFFFF, src_b = 1 -> branch_taken 1, result 0. BLTU on the same operands -> branch_taken 0. BEQ on equal operands -> 1.
- Hold out_ready = 0 for 3 cycles in DONE -> result stable, in_ready 0. Then raise out_ready together with in_valid -> the new op is accepted the same cycle.
- Assert flush during cycle 2 of a 10-position SRL -> IDLE next cycle, out_valid never rises for that op, in_ready 1 the cycle after flush drops. Repeat with rst -> all reset values.
